io_input_conditioner: RTL

Input conditioning stage directly upstream of the IO memory block. It takes the raw, asynchronous, bouncy board inputs (active-low push-buttons and slide switches) and produces clean, synchronous, debounced `keys` and `switches` levels that feed IO memory's `keys` and `switches` inputs. It also keeps sticky per-key press flags. The processor reads these flags at `ADDR_KEY` (32'hF0000010), and the read clears them, so a short button tap is never lost between polls.

---
 rtl/io_pkg.sv | 17 +
 rtl/io_debounce_bit.sv | 51 +++++
 rtl/io_input_conditioner.sv | 80 ++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared IO map constants and input-conditioner sizing used by the IO memory
// block and the board-input conditioner.
package io_pkg;

  localparam logic [31:0] ADDR_HEX  = 32'hF000_0000;
  localparam logic [31:0] ADDR_LEDR = 32'hF000_0004;
  localparam logic [31:0] ADDR_LEDG = 32'hF000_0008;
  localparam logic [31:0] ADDR_KEY  = 32'hF000_0010;
  localparam logic [31:0] ADDR_SW   = 32'hF000_0014;

  localparam int KEY_BITS = 4;
  localparam int SW_BITS  = 10;

  localparam int DEBOUNCE_CYCLES     = 500000;
  localparam int DEBOUNCE_CYCLES_SIM = 4;

endpackage

// File: rtl/io_debounce_bit.sv
// One input channel: 2-flop synchronizer followed by a debounce counter that
// accepts a new level only after DEBOUNCE_CYCLES consecutive cycles of it.
module io_debounce_bit
  import io_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = io_pkg::DEBOUNCE_CYCLES,
  parameter logic SYNC_RST        = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);

  localparam int              CW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle where the synced level agrees with stable restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == TERM) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= SYNC_RST;
      sync2_q  <= SYNC_RST;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/io_input_conditioner.sv
// Debounced key/switch levels plus sticky per-key press flags that the CPU
// clears by reading ADDR_KEY, so short taps survive between polls.
module io_input_conditioner #(
  parameter int KEY_BITS        = io_pkg::KEY_BITS,
  parameter int SW_BITS         = io_pkg::SW_BITS,
  parameter int DEBOUNCE_CYCLES = io_pkg::DEBOUNCE_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [KEY_BITS-1:0] key_n_raw,
  input  logic [SW_BITS-1:0]  sw_raw,
  input  logic                keyClr,
  output logic [KEY_BITS-1:0] keys,
  output logic [SW_BITS-1:0]  switches,
  output logic [KEY_BITS-1:0] keyPressed,
  output logic                keyEvent
);

  import io_pkg::*;

  logic [KEY_BITS-1:0] key_raw;
  logic [KEY_BITS-1:0] key_stable;
  logic [SW_BITS-1:0]  sw_stable;
  logic [KEY_BITS-1:0] key_dly_q;
  logic [KEY_BITS-1:0] rise;
  logic [KEY_BITS-1:0] key_pressed_q, key_pressed_d;
  logic                key_event_q, key_event_d;

  // Buttons are active-low on the board; everything past here is active-high.
  assign key_raw = ~key_n_raw;

  for (genvar g = 0; g < KEY_BITS; g++) begin : g_key
    io_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_RST        (1'b0)
    ) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (key_raw[g]),
      .stable (key_stable[g])
    );
  end

  for (genvar g = 0; g < SW_BITS; g++) begin : g_sw
    io_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_RST        (1'b0)
    ) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (sw_raw[g]),
      .stable (sw_stable[g])
    );
  end

  // A rise on a bit beats a simultaneous clear for that bit only.
  always_comb begin
    rise          = key_stable & ~key_dly_q;
    key_event_d   = |rise;
    key_pressed_d = rise | (keyClr ? '0 : key_pressed_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_dly_q     <= '0;
      key_pressed_q <= '0;
      key_event_q   <= 1'b0;
    end else begin
      key_dly_q     <= key_stable;
      key_pressed_q <= key_pressed_d;
      key_event_q   <= key_event_d;
    end
  end

  assign keys       = key_stable;
  assign switches   = sw_stable;
  assign keyPressed = key_pressed_q;
  assign keyEvent   = key_event_q;

endmodule
